// File: rtl/bp_fe_queue_fence_rolly_fifo.sv
// Speculative-read FIFO: reads (rptr) run ahead of commits (cptr) and can be
// rolled back to the commit point; a fence blocks both ends and optionally
// flushes the queue when it is lifted.
module bp_fe_queue_fence_rolly_fifo #(
    parameter int unsigned width_p            = 64,
    parameter int unsigned els_p              = 8,
    parameter int unsigned ready_THEN_valid_p = 1,
    parameter int unsigned clr_on_fence_clr_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic [width_p-1:0]           data_i,
    input  logic                         v_i,
    output logic                         ready_o,

    output logic [width_p-1:0]           data_o,
    output logic                         v_o,
    input  logic                         yumi_i,

    input  logic                         deq_v_i,
    input  logic                         roll_v_i,
    input  logic                         clr_v_i,

    input  logic                         fence_set_i,
    input  logic                         fence_clr_i,
    output logic                         fence_o,

    output logic [$clog2(els_p+1)-1:0]   occupancy_o,
    output logic [$clog2(els_p+1)-1:0]   spec_cnt_o
);

    localparam int unsigned idx_w_lp = $clog2(els_p);
    localparam int unsigned ptr_w_lp = idx_w_lp + 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [ptr_w_lp-1:0] r_wptr, r_rptr, r_cptr;
    logic [ptr_w_lp-1:0] w_wptr_n, w_rptr_n, w_cptr_n;
    logic [ptr_w_lp-1:0] w_occ, w_spec;
    logic                r_fence;

    logic [width_p-1:0]  r_mem [els_p];

    logic w_full, w_empty;
    logic w_enq, w_yumi, w_deq, w_clr;

    assign w_occ   = r_wptr - r_cptr;
    assign w_spec  = r_rptr - r_cptr;
    assign w_full  = (w_occ == ptr_w_lp'(els_p));
    assign w_empty = (r_rptr == r_wptr);

    assign ready_o = ~w_full & ~r_fence;
    assign v_o     = ~w_empty & ~r_fence;
    assign fence_o = r_fence;

    assign data_o      = r_mem[r_rptr[idx_w_lp-1:0]];
    assign occupancy_o = cnt_w_lp'(w_occ);
    assign spec_cnt_o  = cnt_w_lp'(w_spec);

    // Effective handshakes; illegal yumi/deq are dropped rather than corrupting pointers.
    assign w_enq  = v_i & ready_o;
    assign w_yumi = yumi_i & v_o;
    assign w_deq  = deq_v_i & (r_rptr != r_cptr);
    assign w_clr  = clr_v_i | ((clr_on_fence_clr_p != 0) & fence_clr_i & r_fence);

    // Next pointers: clear beats roll beats yumi on rptr, clear beats deq on cptr.
    always_comb begin
        w_wptr_n = r_wptr + ptr_w_lp'(w_enq);
        w_cptr_n = r_cptr;
        w_rptr_n = r_rptr;
        if (w_clr) begin
            w_cptr_n = r_wptr;
        end else if (w_deq) begin
            w_cptr_n = r_cptr + ptr_w_lp'(1);
        end
        if (w_clr) begin
            w_rptr_n = r_wptr;
        end else if (roll_v_i) begin
            w_rptr_n = w_cptr_n;
        end else if (w_yumi) begin
            w_rptr_n = r_rptr + ptr_w_lp'(1);
        end
    end

    // Pointer and fence state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cptr  <= '0;
            r_fence <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_rptr_n;
            r_cptr  <= w_cptr_n;
            r_fence <= fence_set_i | (r_fence & ~fence_clr_i);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[idx_w_lp-1:0]] <= data_i;
        end
    end

    // Protocol checks for the consumer and producer.
    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_v_i && (r_rptr == r_cptr)));
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !v_o));
    a_ready_then_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (ready_THEN_valid_p == 0) || !(v_i && !ready_o));

endmodule

// File: tb/tb_bp_fe_queue_fence_rolly_fifo.sv
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_bp_fe_queue_fence_rolly_fifo;

    localparam int unsigned W   = 16;
    localparam int unsigned ELS = 4;
    localparam int unsigned CW  = $clog2(ELS + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [W-1:0]  data_i;
    logic          v_i, yumi_i, deq_v_i, roll_v_i, clr_v_i, fence_set_i, fence_clr_i;
    logic          ready_o, v_o, fence_o;
    logic [W-1:0]  data_o;
    logic [CW-1:0] occupancy_o, spec_cnt_o;

    int errors = 0;
    int checks = 0;

    // Model: committed entries in order, how many of them are speculatively read, fence.
    logic [W-1:0] mq[$];
    int           ms;
    bit           mf;

    bp_fe_queue_fence_rolly_fifo #(
        .width_p(W), .els_p(ELS), .ready_THEN_valid_p(1), .clr_on_fence_clr_p(1)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
        .deq_v_i(deq_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
        .fence_set_i(fence_set_i), .fence_clr_i(fence_clr_i), .fence_o(fence_o),
        .occupancy_o(occupancy_o), .spec_cnt_o(spec_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        v_i = 0; data_i = '0; yumi_i = 0; deq_v_i = 0; roll_v_i = 0;
        clr_v_i = 0; fence_set_i = 0; fence_clr_i = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset_n_i = 0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1;
        mq.delete(); ms = 0; mf = 0;
    endtask

    // One clock of stimulus; the model advances by the same cycle.
    task automatic step(input bit v, input logic [W-1:0] d, input bit y, input bit dq,
                        input bit rl, input bit cl, input bit fs, input bit fc);
        bit m_ready, m_v, enq, clear;
        m_ready = !mf && (mq.size() < ELS);
        m_v     = !mf && (ms < mq.size());
        enq     = v && m_ready;
        clear   = cl || (fc && mf);
        v_i = v; data_i = d; yumi_i = y; deq_v_i = dq; roll_v_i = rl;
        clr_v_i = cl; fence_set_i = fs; fence_clr_i = fc;
        if (clear) begin
            mq.delete(); ms = 0;
        end else begin
            if (dq && ms > 0) begin
                void'(mq.pop_front()); ms--;
            end
            if (rl) ms = 0;
            else if (y && m_v) ms++;
        end
        if (enq) mq.push_back(d);
        mf = fs || (mf && !fc);
        @(posedge clk_i);
        #1 idle_inputs();
    endtask

    task automatic enq(input logic [W-1:0] d);
        step(1, d, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%0b exp=0", v_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
        checks++; if (occupancy_o !== CW'(0)) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
        checks++; if (spec_cnt_o !== CW'(0)) begin errors++; $display("FAIL reset_spec got=%0d exp=0", spec_cnt_o); end
        checks++; if (fence_o !== 1'b0) begin errors++; $display("FAIL reset_fence got=%0b exp=0", fence_o); end
    endtask

    task automatic test_full_wrap();
        logic [W-1:0] exp_rd [4];
        exp_rd[0] = 16'h00B1; exp_rd[1] = 16'h00C2; exp_rd[2] = 16'h00D3; exp_rd[3] = 16'h00E4;
        reset_dut();
        enq(16'h00A0); enq(16'h00B1); enq(16'h00C2); enq(16'h00D3);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", ready_o); end
        checks++; if (occupancy_o !== CW'(4)) begin errors++; $display("FAIL full_occ got=%0d exp=4", occupancy_o); end
        checks++; if (data_o !== 16'h00A0) begin errors++; $display("FAIL full_head got=%h exp=00a0", data_o); end
        step(0, '0, 1, 0, 0, 0, 0, 0);
        checks++; if (spec_cnt_o !== CW'(1)) begin errors++; $display("FAIL full_spec got=%0d exp=1", spec_cnt_o); end
        step(0, '0, 0, 1, 0, 0, 0, 0);
        checks++; if (ready_o !== 1'b1 || occupancy_o !== CW'(3)) begin
            errors++; $display("FAIL full_after_deq ready=%0b occ=%0d exp ready=1 occ=3", ready_o, occupancy_o); end
        enq(16'h00E4);
        checks++; if (occupancy_o !== CW'(4)) begin errors++; $display("FAIL full_reenq_occ got=%0d exp=4", occupancy_o); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (v_o !== 1'b1 || data_o !== exp_rd[i]) begin
                errors++; $display("FAIL full_read%0d v=%0b data=%h exp v=1 data=%h", i, v_o, data_o, exp_rd[i]);
            end
            step(0, '0, 1, 0, 0, 0, 0, 0);
        end
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL full_drained v_o got=%0b exp=0", v_o); end
    endtask

    task automatic test_roll();
        reset_dut();
        enq(16'h1111); enq(16'h2222); enq(16'h3333);
        step(0, '0, 1, 0, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0, 0, 0);
        checks++; if (spec_cnt_o !== CW'(2)) begin errors++; $display("FAIL roll_spec_pre got=%0d exp=2", spec_cnt_o); end
        step(0, '0, 0, 0, 1, 0, 0, 0);
        checks++; if (data_o !== 16'h1111 || spec_cnt_o !== CW'(0)) begin
            errors++; $display("FAIL roll_rewind data=%h spec=%0d exp data=1111 spec=0", data_o, spec_cnt_o); end
    endtask

    task automatic test_deq_roll();
        reset_dut();
        enq(16'h4444); enq(16'h5555); enq(16'h6666);
        step(0, '0, 1, 0, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0, 0, 0);
        checks++; if (occupancy_o !== CW'(2) || spec_cnt_o !== CW'(0)) begin
            errors++; $display("FAIL deqroll_cnt occ=%0d spec=%0d exp occ=2 spec=0", occupancy_o, spec_cnt_o); end
        checks++; if (data_o !== 16'h5555 || v_o !== 1'b1) begin
            errors++; $display("FAIL deqroll_data data=%h v=%0b exp data=5555 v=1", data_o, v_o); end
    endtask

    task automatic test_fence();
        reset_dut();
        enq(16'h7777); enq(16'h8888);
        step(0, '0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (v_o !== 1'b0 || ready_o !== 1'b0 || fence_o !== 1'b1) begin
                errors++; $display("FAIL fence_hold%0d v=%0b ready=%0b fence=%0b exp 0/0/1", i, v_o, ready_o, fence_o);
            end
            step(0, '0, 0, 0, 0, 0, 0, 0);
        end
        step(0, '0, 0, 0, 0, 0, 0, 1);
        checks++; if (fence_o !== 1'b0 || occupancy_o !== CW'(0) || v_o !== 1'b0) begin
            errors++; $display("FAIL fence_clr fence=%0b occ=%0d v=%0b exp 0/0/0", fence_o, occupancy_o, v_o); end
        step(0, '0, 0, 0, 0, 0, 1, 1);
        checks++; if (fence_o !== 1'b1) begin errors++; $display("FAIL fence_set_clr got=%0b exp=1", fence_o); end
        step(0, '0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_clr_enq();
        reset_dut();
        enq(16'h9999); enq(16'hAAAA);
        step(0, '0, 1, 0, 0, 0, 0, 0);
        step(1, 16'hBEEF, 0, 0, 0, 1, 0, 0);
        checks++; if (occupancy_o !== CW'(1) || spec_cnt_o !== CW'(0)) begin
            errors++; $display("FAIL clrenq_cnt occ=%0d spec=%0d exp occ=1 spec=0", occupancy_o, spec_cnt_o); end
        checks++; if (data_o !== 16'hBEEF || v_o !== 1'b1) begin
            errors++; $display("FAIL clrenq_data data=%h v=%0b exp data=beef v=1", data_o, v_o); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        enq(16'h0001); enq(16'h0002); enq(16'h0003); enq(16'h0004);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL areset_prefull ready got=%0b exp=0", ready_o); end
        #2 reset_n_i = 0;
        #1;
        checks++; if (v_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== CW'(0)) begin
            errors++; $display("FAIL areset_now v=%0b ready=%0b occ=%0d exp 0/1/0", v_o, ready_o, occupancy_o); end
        @(posedge clk_i);
        #1 reset_n_i = 1;
        mq.delete(); ms = 0; mf = 0;
    endtask

    task automatic test_random();
        bit v, y, dq, rl, cl, fs, fc, m_v, m_ready;
        logic [W-1:0] exp_d;
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            m_ready = !mf && (mq.size() < ELS);
            m_v     = !mf && (ms < mq.size());
            checks++;
            if (v_o !== m_v || ready_o !== m_ready || fence_o !== mf ||
                occupancy_o !== CW'(mq.size()) || spec_cnt_o !== CW'(ms)) begin
                errors++;
                $display("FAIL rand_state cyc=%0d got v=%0b rdy=%0b f=%0b occ=%0d spec=%0d exp v=%0b rdy=%0b f=%0b occ=%0d spec=%0d",
                         c, v_o, ready_o, fence_o, occupancy_o, spec_cnt_o, m_v, m_ready, mf, mq.size(), ms);
            end
            if (m_v) begin
                exp_d = mq[ms];
                checks++;
                if (data_o !== exp_d) begin
                    errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, data_o, exp_d);
                end
            end
            v  = m_ready && ($urandom_range(9) < 6);
            y  = m_v && ($urandom_range(9) < 5);
            dq = (ms > 0) && ($urandom_range(9) < 4);
            rl = ($urandom_range(99) < 5);
            cl = ($urandom_range(99) < 3);
            fs = ($urandom_range(99) < 4);
            fc = mf ? ($urandom_range(9) < 3) : ($urandom_range(99) < 2);
            step(v, W'($urandom), y, dq, rl, cl, fs, fc);
        end
    endtask

    initial begin
        reset_n_i = 0;
        idle_inputs();
        mq.delete(); ms = 0; mf = 0;
        test_reset();
        test_full_wrap();
        test_roll();
        test_deq_roll();
        test_fence();
        test_clr_enq();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_fe_queue_fence_rolly_fifo.md
BP_FE_QUEUE_FENCE_ROLLY_FIFO -- requirements
Module: bp_fe_queue_fence_rolly_fifo

Interface
REQ-001 SHALL have parameter width_p, default 64: entry width in bits.
REQ-002 SHALL have parameter els_p, default 8: entry count; must be a power of two and at least 2.
REQ-003 SHALL have parameter ready_THEN_valid_p, default 1: 1 means the producer may assert v_i only when ready_o is high.
REQ-004 SHALL have parameter clr_on_fence_clr_p, default 1: 1 means a fence clear while the fence is set also clears the queue.
REQ-005 SHALL have ports: clk_i input 1, the only clock; reset_n_i input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: data_i input width_p; v_i input 1; ready_o output 1 (enqueue side).
REQ-007 SHALL have ports: data_o output width_p; v_o output 1; yumi_i input 1 (speculative read side).
REQ-008 SHALL have ports: deq_v_i input 1, commit oldest read entry; roll_v_i input 1, rewind reads to commit point; clr_v_i input 1, discard all entries.
REQ-009 SHALL have ports: fence_set_i input 1; fence_clr_i input 1; fence_o output 1.
REQ-010 SHALL have ports: occupancy_o output $clog2(els_p+1), committed-to-write entry count; spec_cnt_o output $clog2(els_p+1), read-but-uncommitted entry count.

Function
REQ-011 SHALL keep three pointers wptr, rptr, cptr, each $clog2(els_p)+1 bits with a wrap bit; all arithmetic is modulo 2*els_p.
REQ-012 SHALL define full as (wptr-cptr)==els_p and empty as rptr==wptr.
REQ-013 SHALL drive ready_o = ~full & ~fence_o.
REQ-014 SHALL drive v_o = ~empty & ~fence_o.
REQ-015 SHALL drive data_o from the storage entry at rptr, combinationally, with zero-cycle read latency.
REQ-016 SHALL, on v_i & ready_o, write data_i at wptr and increment wptr; the entry becomes visible on v_o the next cycle.
REQ-017 SHALL, on yumi_i (legal only when v_o is high), increment rptr.
REQ-018 SHALL, on deq_v_i (legal only when rptr!=cptr), increment cptr; an illegal deq is ignored and flagged by a simulation assertion.
REQ-019 SHALL, on roll_v_i, set rptr to the post-deq cptr value; yumi_i in the same cycle is ignored.
REQ-020 SHALL, on the effective clear (clr_v_i, or fence_clr_i & fence_o when clr_on_fence_clr_p=1), set rptr and cptr to the pre-update wptr.
REQ-021 SHALL apply the following when an enqueue coincides with an effective clear: the enqueued entry is retained, giving occupancy 1 the next cycle.
REQ-022 SHALL apply update priority clear > roll > yumi for rptr, and clear > deq for cptr.
REQ-023 SHALL update fence_o <= fence_set_i | (fence_o & ~fence_clr_i); a simultaneous set and clear leaves the fence set.
REQ-024 SHALL drive occupancy_o = wptr-cptr and spec_cnt_o = rptr-cptr, both from registered pointers.
REQ-025 SHALL, when wptr reaches index els_p-1 and advances, wrap the index to 0 and toggle the wrap bit; the same rule applies to rptr and cptr.
REQ-026 SHALL, with ready_THEN_valid_p=0, ignore v_i while ready_o is low; with ready_THEN_valid_p=1, such an enqueue is flagged by an assertion.

Reset
REQ-027 SHALL, while reset_n_i is low, asynchronously force wptr, rptr and cptr to 0 and fence_o to 0, giving v_o=0, ready_o=1, occupancy_o=0 and spec_cnt_o=0.
REQ-028 SHALL, on reset assertion mid-operation, discard all stored entries and any in-flight handshake; storage contents need no reset.

Verification
REQ-029 SHALL cover: els_p=4, enqueue A,B,C,D -> ready_o=0 and occupancy_o=4; yumi A, deq, then one more enqueue -> accepted, and E is read fifth.
REQ-030 SHALL cover: enqueue 3 entries, yumi 2 (spec_cnt_o=2), then roll_v_i -> next cycle data_o is the first entry and spec_cnt_o=0.
REQ-031 SHALL cover: yumi 2, then deq_v_i and roll_v_i in the same cycle -> cptr advances 1, rptr equals cptr, spec_cnt_o=0, and data_o is the second entry.
REQ-032 SHALL cover: fence_set_i, then v_o and ready_o held 0 for 3 cycles, then fence_clr_i with 2 entries queued -> fence_o=0, occupancy_o=0 and v_o=0 the next cycle.
REQ-033 SHALL cover: clr_v_i in the same cycle as an enqueue of X -> next cycle occupancy_o=1 and data_o=X.
REQ-034 SHALL cover: pulse reset_n_i low mid-stream with the queue full -> v_o=0, ready_o=1 and occupancy_o=0 immediately, without waiting for a clock edge.
